// File: rtl/reg_status_file_pkg.sv
// Shared parameters for the architectural register / rename-label file.
//   XLEN     : data width of one architectural register
//   NREG     : number of architectural registers (power of two)
//   AW       : register address width
//   TAG_W    : ROB tag width; TAG_NONE (0) means "value valid, no producer"
//   NRD      : number of combinational read ports
package reg_status_file_pkg;
  localparam int XLEN  = 32;
  localparam int NREG  = 32;
  localparam int AW    = $clog2(NREG);
  localparam int TAG_W = 5;
  localparam int NRD   = 2;

  localparam logic [TAG_W-1:0] TAG_NONE = '0;
  localparam logic [AW-1:0]    REG_X0   = '0;
endpackage

// File: rtl/reg_status_file_if.sv
// Bus between decoder/ROB (master) and the register status file (slave).
//   rdy_in      : global enable; low holds all state and disables read bypass
//   flush       : clear every label, ignore the same-cycle rename
//   rename_*    : issue-time binding of a destination to a ROB tag
//   commit_*    : retirement of one result
//   rd_addr     : packed read addresses, port k at [k*AW +: AW]
//   rd_val/tag  : packed read results per port
//   busy_cnt    : registered count of registers with a nonzero label
// Handshake: there is no per-request back-pressure. rename_en and commit_en
// are single-cycle requests that take effect on the rising clock edge only
// when rdy_in is high; with rdy_in low they are ignored and nothing changes.
interface reg_status_file_if;
  import reg_status_file_pkg::*;

  logic                  rdy_in;
  logic                  flush;
  logic                  rename_en;
  logic [AW-1:0]         rename_rd;
  logic [TAG_W-1:0]      rename_tag;
  logic                  commit_en;
  logic [AW-1:0]         commit_rd;
  logic [TAG_W-1:0]      commit_tag;
  logic [XLEN-1:0]       commit_val;
  logic [NRD*AW-1:0]     rd_addr;
  logic [NRD*XLEN-1:0]   rd_val;
  logic [NRD*TAG_W-1:0]  rd_tag;
  logic [AW:0]           busy_cnt;

  modport master (
    output rdy_in, flush, rename_en, rename_rd, rename_tag,
           commit_en, commit_rd, commit_tag, commit_val, rd_addr,
    input  rd_val, rd_tag, busy_cnt
  );

  modport slave (
    input  rdy_in, flush, rename_en, rename_rd, rename_tag,
           commit_en, commit_rd, commit_tag, commit_val, rd_addr,
    output rd_val, rd_tag, busy_cnt
  );
endinterface

// File: rtl/reg_status_file_read_port.sv
// One combinational read port with commit-to-read bypass.
//   addr        : register being read
//   cur_val/tag : stored value and label of addr
//   commit_hit  : a commit is taking effect this cycle (commit_en && rdy_in)
//   commit_*    : retiring destination, tag and value
//   rd_val/tag  : read result; x0 always reads 0/0
// The same-cycle rename is deliberately not visible here.
module reg_status_file_read_port
  import reg_status_file_pkg::*;
(
  input  logic [AW-1:0]    addr,
  input  logic [XLEN-1:0]  cur_val,
  input  logic [TAG_W-1:0] cur_tag,
  input  logic             commit_hit,
  input  logic [AW-1:0]    commit_rd,
  input  logic [TAG_W-1:0] commit_tag,
  input  logic [XLEN-1:0]  commit_val,
  output logic [XLEN-1:0]  rd_val,
  output logic [TAG_W-1:0] rd_tag
);
  always_comb begin
    rd_val = cur_val;
    rd_tag = cur_tag;
    if (addr == REG_X0) begin
      rd_val = '0;
      rd_tag = TAG_NONE;
    end else if (commit_hit && (commit_rd == addr)) begin
      rd_val = commit_val;
      // The label only clears if the retiring instruction is still the
      // youngest producer; a newer rename keeps the register pending.
      rd_tag = (cur_tag == commit_tag) ? TAG_NONE : cur_tag;
    end
  end
endmodule

// File: rtl/reg_status_file.sv
// Architectural register file with rename-label table and NRD read ports.
//   clk     : clock, rising edge
//   rst_in  : asynchronous reset, active high; clears values, labels, busy_cnt
//   bus     : slave side of reg_status_file_if (rename, commit, reads)
// Priority on one edge: reset > flush > rename > commit for labels; the
// commit value write happens whenever the commit is enabled, even on flush.
module reg_status_file
  import reg_status_file_pkg::*;
(
  input logic               clk,
  input logic               rst_in,
  reg_status_file_if.slave  bus
);
  logic [XLEN-1:0]  value_q [NREG];
  logic [TAG_W-1:0] label_q [NREG];
  logic [AW:0]      busy_q;
  logic [AW:0]      busy_nxt;

  logic rename_go;
  logic commit_go;
  logic commit_clears;
  logic rename_sets;

  assign rename_go = bus.rdy_in && bus.rename_en && !bus.flush &&
                     (bus.rename_rd != REG_X0);
  assign commit_go = bus.rdy_in && bus.commit_en && (bus.commit_rd != REG_X0);

  // A commit clears a pending label only when it matches, and not when a
  // rename of the same register overrides it on this edge.
  assign commit_clears = commit_go && !bus.flush &&
                         (label_q[bus.commit_rd] == bus.commit_tag) &&
                         (label_q[bus.commit_rd] != TAG_NONE) &&
                         !(rename_go && (bus.rename_rd == bus.commit_rd));
  assign rename_sets   = rename_go && (label_q[bus.rename_rd] == TAG_NONE);

  always_comb begin
    busy_nxt = busy_q;
    if (bus.flush) begin
      busy_nxt = '0;
    end else begin
      case ({rename_sets, commit_clears})
        2'b10:   busy_nxt = busy_q + (AW+1)'(1);
        2'b01:   busy_nxt = busy_q - (AW+1)'(1);
        default: busy_nxt = busy_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < NREG; i++) begin
        value_q[i] <= '0;
        label_q[i] <= TAG_NONE;
      end
      busy_q <= '0;
    end else if (bus.rdy_in) begin
      if (commit_go) begin
        value_q[bus.commit_rd] <= bus.commit_val;
      end
      if (bus.flush) begin
        for (int i = 0; i < NREG; i++) begin
          label_q[i] <= TAG_NONE;
        end
      end else begin
        if (commit_clears) begin
          label_q[bus.commit_rd] <= TAG_NONE;
        end
        if (rename_go) begin
          label_q[bus.rename_rd] <= bus.rename_tag;
        end
      end
      busy_q <= busy_nxt;
    end
  end

  assign bus.busy_cnt = busy_q;

  logic [NRD*XLEN-1:0]  rd_val_w;
  logic [NRD*TAG_W-1:0] rd_tag_w;
  logic                 commit_hit;

  assign commit_hit = bus.commit_en && bus.rdy_in;

  for (genvar k = 0; k < NRD; k++) begin : g_port
    logic [AW-1:0] a;
    assign a = bus.rd_addr[k*AW +: AW];

    reg_status_file_read_port u_port (
      .addr       (a),
      .cur_val    (value_q[a]),
      .cur_tag    (label_q[a]),
      .commit_hit (commit_hit),
      .commit_rd  (bus.commit_rd),
      .commit_tag (bus.commit_tag),
      .commit_val (bus.commit_val),
      .rd_val     (rd_val_w[k*XLEN +: XLEN]),
      .rd_tag     (rd_tag_w[k*TAG_W +: TAG_W])
    );
  end

  assign bus.rd_val = rd_val_w;
  assign bus.rd_tag = rd_tag_w;
endmodule

// File: tb/tb_reg_status_file.sv
// Self-checking bench for reg_status_file: directed vector table, async
// reset sequences, and randomized traffic against a behavioural model.
module tb_reg_status_file;
  import reg_status_file_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_in;
  always #5 clk = ~clk;

  reg_status_file_if bus ();

  reg_status_file dut (
    .clk    (clk),
    .rst_in (rst_in),
    .bus    (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // ---------------- reference model ----------------
  logic [XLEN-1:0]  m_val [NREG];
  logic [TAG_W-1:0] m_lab [NREG];

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) begin
      m_val[i] = '0;
      m_lab[i] = '0;
    end
  endtask

  function automatic int model_busy();
    int c = 0;
    for (int i = 0; i < NREG; i++) if (m_lab[i] != 0) c++;
    return c;
  endfunction

  // Read result as seen before the edge, from the current inputs.
  function automatic logic [XLEN-1:0] model_rd_val(input logic [AW-1:0] a);
    if (a == 0) return '0;
    if (bus.commit_en && bus.rdy_in && bus.commit_rd == a) return bus.commit_val;
    return m_val[a];
  endfunction

  function automatic logic [TAG_W-1:0] model_rd_tag(input logic [AW-1:0] a);
    if (a == 0) return '0;
    if (bus.commit_en && bus.rdy_in && bus.commit_rd == a)
      return (m_lab[a] == bus.commit_tag) ? '0 : m_lab[a];
    return m_lab[a];
  endfunction

  // Apply one clock edge's worth of architectural rules, in order:
  // commit (older) then rename (younger) overrides, flush wipes labels.
  task automatic model_step();
    if (!bus.rdy_in) return;
    if (bus.commit_en && bus.commit_rd != 0) begin
      m_val[bus.commit_rd] = bus.commit_val;
      if (m_lab[bus.commit_rd] == bus.commit_tag) m_lab[bus.commit_rd] = '0;
    end
    if (bus.flush) begin
      for (int i = 0; i < NREG; i++) m_lab[i] = '0;
    end else if (bus.rename_en && bus.rename_rd != 0) begin
      m_lab[bus.rename_rd] = bus.rename_tag;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ren, input logic [AW-1:0] rrd, input logic [TAG_W-1:0] rtag,
                       input logic cen, input logic [AW-1:0] crd, input logic [TAG_W-1:0] ctag,
                       input logic [XLEN-1:0] cval, input logic fl, input logic rdy,
                       input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    bus.rename_en  = ren;
    bus.rename_rd  = rrd;
    bus.rename_tag = rtag;
    bus.commit_en  = cen;
    bus.commit_rd  = crd;
    bus.commit_tag = ctag;
    bus.commit_val = cval;
    bus.flush      = fl;
    bus.rdy_in     = rdy;
    bus.rd_addr    = {a1, a0};
  endtask

  task automatic drive_idle(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    drive(1'b0, '0, '0, 1'b0, '0, '0, '0, 1'b0, 1'b1, a0, a1);
  endtask

  task automatic check_ports_vs_model(input string tag);
    for (int k = 0; k < NRD; k++) begin
      logic [AW-1:0] a;
      a = bus.rd_addr[k*AW +: AW];
      check($sformatf("%s rd_val[%0d] x%0d", tag, k, a),
            64'(bus.rd_val[k*XLEN +: XLEN]), 64'(model_rd_val(a)));
      check($sformatf("%s rd_tag[%0d] x%0d", tag, k, a),
            64'(bus.rd_tag[k*TAG_W +: TAG_W]), 64'(model_rd_tag(a)));
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic             ren;
    logic [AW-1:0]    rrd;
    logic [TAG_W-1:0] rtag;
    logic             cen;
    logic [AW-1:0]    crd;
    logic [TAG_W-1:0] ctag;
    logic [XLEN-1:0]  cval;
    logic             fl;
    logic             rdy;
    logic [AW-1:0]    a0;
    logic [AW-1:0]    a1;
    logic [XLEN-1:0]  e_v0;
    logic [TAG_W-1:0] e_t0;
    logic [XLEN-1:0]  e_v1;
    logic [TAG_W-1:0] e_t1;
    int               e_busy;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic ren, input int rrd, input int rtag,
                     input logic cen, input int crd, input int ctag, input int cval,
                     input logic fl, input logic rdy, input int a0, input int a1,
                     input int ev0, input int et0, input int ev1, input int et1, input int eb);
    vec_t v;
    v.ren = ren; v.rrd = AW'(rrd); v.rtag = TAG_W'(rtag);
    v.cen = cen; v.crd = AW'(crd); v.ctag = TAG_W'(ctag); v.cval = XLEN'(cval);
    v.fl = fl; v.rdy = rdy; v.a0 = AW'(a0); v.a1 = AW'(a1);
    v.e_v0 = XLEN'(ev0); v.e_t0 = TAG_W'(et0);
    v.e_v1 = XLEN'(ev1); v.e_t1 = TAG_W'(et1); v.e_busy = eb;
    tbl.push_back(v);
  endtask

  initial begin
    //  ren rrd rt  cen crd ct cval  fl rdy a0 a1   ev0  et0 ev1  et1 busy
    add(0,  0,  0,  0,  0,  0, 0,    0, 1,  5, 5,   0,   0,  0,   0,  0);
    add(1,  5,  3,  0,  0,  0, 0,    0, 1,  5, 5,   0,   0,  0,   0,  1);
    add(0,  0,  0,  0,  0,  0, 0,    0, 1,  5, 0,   0,   3,  0,   0,  1);
    add(0,  0,  0,  1,  5,  3, 'h55, 0, 1,  5, 5,   'h55,0,  'h55,0,  0);
    add(0,  0,  0,  0,  0,  0, 0,    0, 1,  5, 5,   'h55,0,  'h55,0,  0);
    add(1,  7,  2,  0,  0,  0, 0,    0, 1,  7, 5,   0,   0,  'h55,0,  1);
    add(1,  7,  4,  0,  0,  0, 0,    0, 1,  7, 7,   0,   2,  0,   2,  1);
    add(0,  0,  0,  1,  7,  2, 9,    0, 1,  7, 7,   9,   4,  9,   4,  1);
    add(0,  0,  0,  0,  0,  0, 0,    0, 1,  7, 7,   9,   4,  9,   4,  1);
    add(1,  8,  6,  1,  8,  1, 'hAA, 0, 1,  8, 7,   'hAA,0,  9,   4,  2);
    add(0,  0,  0,  0,  0,  0, 0,    0, 1,  8, 7,   'hAA,6,  9,   4,  2);
    add(1,  1,  1,  0,  0,  0, 0,    0, 1,  7, 8,   9,   4,  'hAA,6,  3);
    add(1,  2,  2,  0,  0,  0, 0,    0, 1,  7, 8,   9,   4,  'hAA,6,  4);
    add(1,  3,  3,  0,  0,  0, 0,    0, 1,  1, 2,   0,   1,  0,   2,  5);
    add(1,  4,  5,  0,  0,  0, 0,    0, 1,  3, 8,   0,   3,  'hAA,6,  6);
    add(1,  9,  7,  1,  2,  2, 7,    1, 1,  2, 9,   7,   0,  0,   0,  0);
    add(0,  0,  0,  0,  0,  0, 0,    0, 1,  2, 9,   7,   0,  0,   0,  0);
    add(0,  0,  0,  0,  0,  0, 0,    0, 1,  7, 8,   9,   0,  'hAA,0,  0);
    add(1,  10, 3,  0,  0,  0, 0,    0, 1,  10,11,  0,   0,  0,   0,  1);
    add(1,  11, 4,  1,  10, 3, 5,    0, 0,  10,11,  0,   3,  0,   0,  1);
    add(0,  0,  0,  0,  0,  0, 0,    0, 1,  10,11,  0,   3,  0,   0,  1);
    add(1,  0,  3,  1,  0,  3, 'h77, 0, 1,  0, 0,   0,   0,  0,   0,  1);
    add(0,  0,  0,  0,  0,  0, 0,    0, 1,  0, 10,  0,   0,  0,   3,  1);
  end

  // ---------------- main sequence ----------------
  initial begin
    rst_in = 1'b1;
    drive_idle(AW'(5), AW'(5));
    model_reset();
    #1;
    check("reset busy_cnt", 64'(bus.busy_cnt), 64'd0);
    check("reset rd_val[0]", 64'(bus.rd_val[XLEN-1:0]), 64'd0);
    check("reset rd_tag[1]", 64'(bus.rd_tag[2*TAG_W-1:TAG_W]), 64'd0);
    @(negedge clk);
    rst_in = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < tbl.size(); i++) begin
      vec_t v;
      v = tbl[i];
      drive(v.ren, v.rrd, v.rtag, v.cen, v.crd, v.ctag, v.cval, v.fl, v.rdy, v.a0, v.a1);
      #1;
      check($sformatf("vec%0d rd_val0", i), 64'(bus.rd_val[0 +: XLEN]), 64'(v.e_v0));
      check($sformatf("vec%0d rd_tag0", i), 64'(bus.rd_tag[0 +: TAG_W]), 64'(v.e_t0));
      check($sformatf("vec%0d rd_val1", i), 64'(bus.rd_val[XLEN +: XLEN]), 64'(v.e_v1));
      check($sformatf("vec%0d rd_tag1", i), 64'(bus.rd_tag[TAG_W +: TAG_W]), 64'(v.e_t1));
      model_step();
      @(posedge clk);
      #1;
      check($sformatf("vec%0d busy_cnt", i), 64'(bus.busy_cnt), 64'(v.e_busy));
    end

    // Async reset pulse mid-cycle: outputs drop to zero without a clock edge.
    drive_idle(AW'(10), AW'(8));
    #2;
    rst_in = 1'b1;
    #1;
    check("async rst busy_cnt", 64'(bus.busy_cnt), 64'd0);
    check("async rst rd_tag x10", 64'(bus.rd_tag[0 +: TAG_W]), 64'd0);
    check("async rst rd_val x8", 64'(bus.rd_val[XLEN +: XLEN]), 64'd0);
    model_reset();
    #1;
    rst_in = 1'b0;
    @(posedge clk);
    #1;

    // Reset held across an edge overrides a rename and commit on that edge.
    drive(1'b1, AW'(12), TAG_W'(9), 1'b1, AW'(13), TAG_W'(0), XLEN'(32'h1234), 1'b0, 1'b1,
          AW'(12), AW'(13));
    rst_in = 1'b1;
    @(posedge clk);
    #1;
    rst_in = 1'b0;
    drive_idle(AW'(12), AW'(13));
    #1;
    check("rst edge busy_cnt", 64'(bus.busy_cnt), 64'd0);
    check("rst edge tag x12", 64'(bus.rd_tag[0 +: TAG_W]), 64'd0);
    check("rst edge val x13", 64'(bus.rd_val[XLEN +: XLEN]), 64'd0);
    @(posedge clk);
    #1;

    // Randomized traffic on a small register window to force collisions.
    for (int i = 0; i < 400; i++) begin
      logic [AW-1:0]    rrd, crd, a0, a1;
      logic [TAG_W-1:0] rtag, ctag;
      rrd  = AW'($urandom_range(7, 0));
      crd  = AW'($urandom_range(7, 0));
      a0   = ($urandom_range(3, 0) == 0) ? crd : AW'($urandom_range(7, 0));
      a1   = AW'($urandom_range(NREG-1, 0));
      rtag = TAG_W'($urandom_range((1 << TAG_W) - 1, 1));
      ctag = ($urandom_range(1, 0) == 1) ? m_lab[crd] : TAG_W'($urandom_range((1 << TAG_W) - 1, 0));
      drive(1'($urandom_range(1, 0)), rrd, rtag,
            1'($urandom_range(1, 0)), crd, ctag, XLEN'($urandom()),
            ($urandom_range(15, 0) == 0), ($urandom_range(7, 0) != 0), a0, a1);
      #1;
      check_ports_vs_model($sformatf("rnd%0d", i));
      model_step();
      @(posedge clk);
      #1;
      check($sformatf("rnd%0d busy_cnt", i), 64'(bus.busy_cnt), 64'(model_busy()));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
